ram_serial_tx: RTL and testbench

RAM_SERIAL_TX -- requirements
Module: ram_serial_tx

---
 rtl/ram_serial_tx_pkg.sv | 28 ++
 rtl/ram_serial_tx_baud_gen.sv | 30 +++
 rtl/ram_serial_tx.sv | 200 ++++++++++++++++++++
 tb/tb_ram_serial_tx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_serial_tx_pkg.sv
// Shared definitions for the RAM serial transmitter and its receive-side peer.
// Optional feature macro: PARITY_EN (adds an even-parity bit after the data bits).
package ram_serial_tx_pkg;

    localparam int   FRAME_DATA_BITS = 8;
    localparam logic LINE_IDLE       = 1'b1;
    localparam logic START_BIT       = 1'b0;
    localparam logic STOP_BIT        = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_START,
        ST_DATA,
`ifdef PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_NEXT,
        ST_DONE
    } tx_state_t;

    function automatic logic even_parity(input logic [FRAME_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/ram_serial_tx_baud_gen.sv
// Bit-period timer: a down-counter that reloads on clear and on terminal count,
// so bit_tick marks the last cycle of every CLKS_PER_BIT-cycle bit period.
module tx_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Count down to zero, then reload; clear restarts a full bit period.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || (cnt == '0)) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign bit_tick = (cnt == '0);

endmodule

// File: rtl/ram_serial_tx.sv
// Reads word_count words from RAM and sends the low byte of each as a UART-style
// frame on serialOut. Optional feature macro: PARITY_EN (even parity bit).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | line high, waiting for send
//   FETCH   | read_en pulse, addr = word index
//   LOAD    | capture ram_data[7:0], restart bit timer
//   START   | start bit on the line
//   DATA    | 8 data bits, LSB first
//   PARITY  | even parity bit (PARITY_EN builds only)
//   STOP    | stop bit on the line
//   NEXT    | advance word index, decide next word or finish
//   DONE    | one-cycle done pulse
module ram_serial_tx
    import ram_serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              send,
    input  logic [ADDR_W-1:0] word_count,
    input  logic [15:0]       ram_data,
    output logic [ADDR_W-1:0] addr,
    output logic              read_en,
    output logic              serialOut,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] LAST_BIT = 3'(FRAME_DATA_BITS - 1);

    tx_state_t                       state;
    tx_state_t                       next_state;
    logic [ADDR_W-1:0]               word_idx;
    logic [ADDR_W-1:0]               idx_next;
    logic [ADDR_W-1:0]               word_total;
    logic [FRAME_DATA_BITS-1:0]      shift_q;
    logic [2:0]                      bit_cnt;
    logic                            serial_q;
    logic                            baud_clear;
    logic                            bit_tick;
`ifdef PARITY_EN
    logic                            parity_q;
`endif

    // Upper RAM byte is not part of the frame.
    logic unused_ram_hi;
    assign unused_ram_hi = ^ram_data[15:8];

    assign idx_next  = word_idx + ADDR_W'(1);
    assign addr      = word_idx;
    assign serialOut = serial_q;

    tx_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clear   (baud_clear),
        .bit_tick(bit_tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and state-derived strobes.
    always_comb begin
        next_state = state;
        baud_clear = 1'b0;
        read_en    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (send) begin
                    next_state = (word_count == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                read_en    = 1'b1;
                next_state = ST_LOAD;
            end
            ST_LOAD: begin
                baud_clear = 1'b1;
                next_state = ST_START;
            end
            ST_START: begin
                if (bit_tick) next_state = ST_DATA;
            end
            ST_DATA: begin
                if (bit_tick && (bit_cnt == LAST_BIT)) begin
`ifdef PARITY_EN
                    next_state = ST_PARITY;
`else
                    next_state = ST_STOP;
`endif
                end
            end
`ifdef PARITY_EN
            ST_PARITY: begin
                if (bit_tick) next_state = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_tick) next_state = ST_NEXT;
            end
            ST_NEXT: begin
                next_state = (idx_next == word_total) ? ST_DONE : ST_FETCH;
            end
            ST_DONE: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Word bookkeeping, shift register and the registered line driver.
    // serial_q is loaded with the level of the bit that starts on the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_idx   <= '0;
            word_total <= '0;
            shift_q    <= '0;
            bit_cnt    <= '0;
            serial_q   <= LINE_IDLE;
`ifdef PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    serial_q <= LINE_IDLE;
                    if (send) begin
                        word_total <= word_count;
                        word_idx   <= '0;
                    end
                end
                ST_LOAD: begin
                    shift_q  <= ram_data[FRAME_DATA_BITS-1:0];
                    bit_cnt  <= '0;
                    serial_q <= START_BIT;
`ifdef PARITY_EN
                    parity_q <= even_parity(ram_data[FRAME_DATA_BITS-1:0]);
`endif
                end
                ST_START: begin
                    if (bit_tick) begin
                        serial_q <= shift_q[0];
                        shift_q  <= shift_q >> 1;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
`ifdef PARITY_EN
                            serial_q <= parity_q;
`else
                            serial_q <= STOP_BIT;
`endif
                        end else begin
                            bit_cnt  <= bit_cnt + 3'd1;
                            serial_q <= shift_q[0];
                            shift_q  <= shift_q >> 1;
                        end
                    end
                end
`ifdef PARITY_EN
                ST_PARITY: begin
                    if (bit_tick) serial_q <= STOP_BIT;
                end
`endif
                ST_STOP: begin
                    serial_q <= STOP_BIT;
                end
                ST_NEXT: begin
                    word_idx <= idx_next;
                    serial_q <= LINE_IDLE;
                end
                default: begin
                    serial_q <= LINE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_serial_tx.sv
// Testbench for ram_serial_tx: directed and random transfers checked cycle by
// cycle against a line-level timeline built from the frame rules.
module tb_ram_serial_tx;

    localparam int C  = 4;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          send;
    logic [AW-1:0] word_count;
    logic [15:0]   ram_data;
    logic [AW-1:0] addr;
    logic          read_en;
    logic          serialOut;
    logic          busy;
    logic          done;

    ram_serial_tx #(
        .CLKS_PER_BIT(C),
        .ADDR_W      (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .send      (send),
        .word_count(word_count),
        .ram_data  (ram_data),
        .addr      (addr),
        .read_en   (read_en),
        .serialOut (serialOut),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: data valid the cycle after read_en.
    logic [15:0] ram [0:255];
    always @(posedge clk) if (read_en) ram_data <= ram[addr];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic          line;
        logic          re;
        logic [AW-1:0] a;
        logic          bsy;
        logic          dn;
    } exp_t;

    exp_t q[$];

    // Per-cycle expectation for a transfer of n words, starting with the
    // cycle after send is accepted: fetch, load, frame bits, gap, then done.
    task automatic build(input int n);
        logic [7:0] d;
        logic       lvl;
        int         nbits;
        q.delete();
`ifdef PARITY_EN
        nbits = 11;
`else
        nbits = 10;
`endif
        for (int w = 0; w < n; w++) begin
            d = ram[w][7:0];
            q.push_back('{1'b1, 1'b1, AW'(w), 1'b1, 1'b0});
            q.push_back('{1'b1, 1'b0, '0, 1'b1, 1'b0});
            for (int b = 0; b < nbits; b++) begin
                if (b == 0)                        lvl = 1'b0;
                else if (b <= 8)                   lvl = d[b-1];
                else if (b == 9 && nbits == 11)    lvl = ^d;
                else                               lvl = 1'b1;
                repeat (C) q.push_back('{lvl, 1'b0, '0, 1'b1, 1'b0});
            end
            q.push_back('{1'b1, 1'b0, '0, 1'b1, 1'b0});
        end
        q.push_back('{1'b1, 1'b0, '0, 1'b1, 1'b1});
    endtask

    task automatic launch(input logic [AW-1:0] n);
        @(negedge clk);
        word_count = n;
        send       = 1'b1;
    endtask

    // Checks every cycle of one transfer, then the first idle cycle.
    // word_count is scrambled while busy; it must already be latched.
    task automatic run_xfer(input int n, input bit hold, input logic [AW-1:0] next_wc);
        build(n);
        foreach (q[i]) begin
            @(negedge clk);
            if (!hold) send = 1'b0;
            word_count = AW'($urandom);
            chk("serialOut", 32'(serialOut), 32'(q[i].line));
            chk("read_en", 32'(read_en), 32'(q[i].re));
            if (q[i].re) chk("addr", 32'(addr), 32'(q[i].a));
            chk("busy", 32'(busy), 32'(q[i].bsy));
            chk("done", 32'(done), 32'(q[i].dn));
        end
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_line", 32'(serialOut), 32'd1);
        word_count = next_wc;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        int         n;
        bit         seen_done;
        bit         seen_low;

        for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
        reset      = 1'b1;
        send       = 1'b0;
        word_count = '0;
        repeat (3) @(negedge clk);
        chk("rst_line", 32'(serialOut), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_read_en", 32'(read_en), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        reset = 1'b0;

        // Single word 0x12A5: line 0,1,0,1,0,0,1,0,1,1.
        ram[0] = 16'h12A5;
        launch(1);
        run_xfer(1, 1'b0, '0);

        // Three words back to back.
        ram[0] = 16'h0001; ram[1] = 16'h0080; ram[2] = 16'h00FF;
        launch(3);
        run_xfer(3, 1'b0, '0);

        // Empty buffer: done the cycle after send, line stays high.
        launch(0);
        run_xfer(0, 1'b0, '0);

        // send held high: second transfer only after done.
        ram[0] = 16'h3C5A; ram[1] = 16'hFF81;
        launch(2);
        run_xfer(2, 1'b1, 8'd2);
        run_xfer(2, 1'b0, '0);

        // Parity cases (plain frames when parity is not built in).
        ram[0] = 16'h0007;
        launch(1);
        run_xfer(1, 1'b0, '0);
        ram[0] = 16'h0003;
        launch(1);
        run_xfer(1, 1'b0, '0);

        // Reset during data bit 3 of word 0.
        ram[0] = 16'h00B6;
        d = 8'hB6;
        launch(1);
        @(negedge clk);
        send = 1'b0;
        repeat (2 + 4 * C) @(negedge clk);
        chk("bit3_line", 32'(serialOut), 32'(d[3]));
        reset = 1'b1;
        @(negedge clk);
        chk("abort_line", 32'(serialOut), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        seen_done = 1'b0;
        seen_low  = 1'b0;
        repeat (4 * C) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
            if (!serialOut) seen_low = 1'b1;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);
        chk("abort_line_high", 32'(seen_low), 32'd0);

        // Reset wins over send in the same cycle.
        @(negedge clk);
        reset      = 1'b1;
        send       = 1'b1;
        word_count = 8'd3;
        @(negedge clk);
        chk("rst_prio_busy", 32'(busy), 32'd0);
        chk("rst_prio_read_en", 32'(read_en), 32'd0);
        reset = 1'b0;
        send  = 1'b0;

        // Random buffers and lengths.
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 8; i++) ram[i] = 16'($urandom);
            n = $urandom_range(0, 5);
            launch(AW'(n));
            run_xfer(n, 1'b0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
